// File: rtl/led_ctrl_multi_if.sv
// Configuration port of led_ctrl_multi: one-cycle write strobe towards the controller,
// one-cycle accept/reject pulse back to the writer.
interface led_ctrl_multi_if #(
    parameter int CH_IDX_W = 2,
    parameter int PERIOD_W = 10
);
    logic                cfg_we;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_val;
    logic                cfg_ack;
    logic                cfg_err;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_val,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_val,
        output cfg_ack,
        output cfg_err
    );
endinterface

// File: rtl/led_ctrl_multi.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/PWM modes driven by a shared
// millisecond prescaler and a shared free-running PWM counter; all outputs registered.
module led_ctrl_multi #(
    parameter int NUM_CH    = 4,
    parameter int CH_IDX_W  = 2,
    parameter int PRESC_W   = 16,
    parameter int PRESC_DIV = 25000,
    parameter int PERIOD_W  = 10,
    parameter int PWM_W     = 8
) (
    input  logic              fpga_clk_in,
    input  logic              fpga_rst,
    led_ctrl_multi_if.slave   cfg,
    output logic              tick_out,
    output logic [NUM_CH-1:0] led_out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0]  presc_cnt;
    logic [PRESC_W-1:0]  presc_cnt_nxt;
    logic                tick;
    logic [PWM_W-1:0]    pwm_cnt;

    mode_e               mode_q   [NUM_CH];
    mode_e               mode_nxt [NUM_CH];
    logic [PERIOD_W-1:0] val_q    [NUM_CH];
    logic [PERIOD_W-1:0] val_nxt  [NUM_CH];
    logic [PERIOD_W-1:0] bcnt_q   [NUM_CH];
    logic [PERIOD_W-1:0] bcnt_nxt [NUM_CH];
    logic [NUM_CH-1:0]   bst_q;
    logic [NUM_CH-1:0]   bst_nxt;
    logic [NUM_CH-1:0]   led_nxt;

    logic                wr_valid;
    logic                wr_invalid;

    // A write to the addressed channel overrides a coincident blink tick on that channel.
    always_comb begin
        tick          = (presc_cnt == PRESC_LAST);
        presc_cnt_nxt = tick ? '0 : presc_cnt + 1'b1;
        wr_valid      = cfg.cfg_we && (int'({1'b0, cfg.cfg_ch}) < NUM_CH);
        wr_invalid    = cfg.cfg_we && !wr_valid;
        bst_nxt       = bst_q;
        led_nxt       = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            mode_nxt[i] = mode_q[i];
            val_nxt[i]  = val_q[i];
            bcnt_nxt[i] = bcnt_q[i];

            case (mode_q[i])
                MODE_ON:    led_nxt[i] = 1'b1;
                MODE_BLINK: led_nxt[i] = bst_q[i];
                MODE_PWM:   led_nxt[i] = (pwm_cnt < val_q[i][PWM_W-1:0]);
                default:    led_nxt[i] = 1'b0;
            endcase

            if (wr_valid && (int'({1'b0, cfg.cfg_ch}) == i)) begin
                mode_nxt[i] = mode_e'(cfg.cfg_mode);
                val_nxt[i]  = cfg.cfg_val;
                bcnt_nxt[i] = '0;
                bst_nxt[i]  = 1'b0;
            end else if ((mode_q[i] == MODE_BLINK) && tick) begin
                if (bcnt_q[i] == val_q[i]) begin
                    bcnt_nxt[i] = '0;
                    bst_nxt[i]  = ~bst_q[i];
                end else begin
                    bcnt_nxt[i] = bcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst) begin
            presc_cnt   <= '0;
            pwm_cnt     <= '0;
            tick_out    <= 1'b0;
            led_out     <= '0;
            bst_q       <= '0;
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_OFF;
                val_q[i]  <= '0;
                bcnt_q[i] <= '0;
            end
        end else begin
            presc_cnt   <= presc_cnt_nxt;
            pwm_cnt     <= pwm_cnt + 1'b1;
            tick_out    <= tick;
            led_out     <= led_nxt;
            bst_q       <= bst_nxt;
            cfg.cfg_ack <= wr_valid;
            cfg.cfg_err <= wr_invalid;
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_nxt[i];
                val_q[i]  <= val_nxt[i];
                bcnt_q[i] <= bcnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Bench for led_ctrl_multi (3 channels, 4-clock tick): a cycle-count based model checked
// on every falling edge, plus directed scenarios with hand-computed expectations.
module tb_led_ctrl_multi;

    localparam int NUM_CH    = 3;
    localparam int CH_IDX_W  = 2;
    localparam int PRESC_W   = 16;
    localparam int PRESC_DIV = 4;
    localparam int PERIOD_W  = 10;
    localparam int PWM_W     = 8;
    localparam int PWM_LEN   = 2 ** PWM_W;

    logic              fpga_clk_in = 1'b0;
    logic              fpga_rst;
    logic              tick_out;
    logic [NUM_CH-1:0] led_out;

    int checks = 0;
    int errors = 0;

    led_ctrl_multi_if #(.CH_IDX_W(CH_IDX_W), .PERIOD_W(PERIOD_W)) cfg_bus ();

    led_ctrl_multi #(
        .NUM_CH    (NUM_CH),
        .CH_IDX_W  (CH_IDX_W),
        .PRESC_W   (PRESC_W),
        .PRESC_DIV (PRESC_DIV),
        .PERIOD_W  (PERIOD_W),
        .PWM_W     (PWM_W)
    ) dut (
        .fpga_clk_in (fpga_clk_in),
        .fpga_rst    (fpga_rst),
        .cfg         (cfg_bus),
        .tick_out    (tick_out),
        .led_out     (led_out)
    );

    always #5 fpga_clk_in = ~fpga_clk_in;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: edge k since reset sees prescaler phase k%PRESC_DIV and PWM phase k%PWM_LEN;
    // a blinking channel has toggled once per (val+1) ticks counted since its last write.
    int                m_mode  [NUM_CH];
    int                m_val   [NUM_CH];
    int                m_ticks [NUM_CH];
    int                m_k;
    bit                m_tick;
    logic [NUM_CH-1:0] exp_led;
    logic              exp_ack;
    logic              exp_err;
    logic              exp_tick;

    always @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst) begin
            m_k      = 0;
            exp_led  = '0;
            exp_ack  = 1'b0;
            exp_err  = 1'b0;
            exp_tick = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c]  = 0;
                m_val[c]   = 0;
                m_ticks[c] = 0;
            end
        end else begin
            m_tick = ((m_k % PRESC_DIV) == PRESC_DIV - 1);
            for (int c = 0; c < NUM_CH; c++) begin
                case (m_mode[c])
                    1:       exp_led[c] = 1'b1;
                    2:       exp_led[c] = (((m_ticks[c] / (m_val[c] + 1)) % 2) == 1);
                    3:       exp_led[c] = ((m_k % PWM_LEN) < (m_val[c] % PWM_LEN));
                    default: exp_led[c] = 1'b0;
                endcase
            end
            exp_tick = m_tick;
            exp_ack  = cfg_bus.cfg_we && (int'(cfg_bus.cfg_ch) < NUM_CH);
            exp_err  = cfg_bus.cfg_we && (int'(cfg_bus.cfg_ch) >= NUM_CH);
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_bus.cfg_we && (int'(cfg_bus.cfg_ch) == c)) begin
                    m_mode[c]  = int'(cfg_bus.cfg_mode);
                    m_val[c]   = int'(cfg_bus.cfg_val);
                    m_ticks[c] = 0;
                end else if (m_mode[c] == 2 && m_tick) begin
                    m_ticks[c]++;
                end
            end
            m_k++;
        end
    end

    always @(negedge fpga_clk_in) begin
        check_output("model_led", 32'(led_out), 32'(exp_led));
        check_output("model_ack", 32'(cfg_bus.cfg_ack), 32'(exp_ack));
        check_output("model_err", 32'(cfg_bus.cfg_err), 32'(exp_err));
        check_output("model_tick", 32'(tick_out), 32'(exp_tick));
    end

    task automatic step();
        @(posedge fpga_clk_in);
        #1;
    endtask

    task automatic apply_stimulus(input int ch, input int mode, input int val);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = CH_IDX_W'(ch);
        cfg_bus.cfg_mode = 2'(mode);
        cfg_bus.cfg_val  = PERIOD_W'(val);
        step();
        cfg_bus.cfg_we   = 1'b0;
    endtask

    task automatic wait_toggle(input int idx, input int limit, output int n);
        logic prev;
        prev = led_out[idx];
        n    = 0;
        do begin
            step();
            n++;
        end while ((led_out[idx] == prev) && (n < limit));
        if (led_out[idx] == prev)
            check_output("toggle_timeout", 32'(led_out[idx]), 32'(!prev));
    endtask

    int n;
    int high;

    initial begin
        fpga_rst         = 1'b1;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_mode = '0;
        cfg_bus.cfg_val  = '0;
        repeat (3) step();
        check_output("reset_led", 32'(led_out), 32'd0);
        check_output("reset_tick", 32'(tick_out), 32'd0);
        check_output("reset_ack", 32'(cfg_bus.cfg_ack), 32'd0);
        fpga_rst = 1'b0;
        repeat (5) step();

        $display("[TB] write ch0 ON");
        apply_stimulus(0, 1, 0);
        check_output("on_ack_n", 32'(cfg_bus.cfg_ack), 32'd1);
        check_output("on_led_n", 32'(led_out[0]), 32'd0);
        step();
        check_output("on_ack_n1", 32'(cfg_bus.cfg_ack), 32'd0);
        check_output("on_led_n1", 32'(led_out[0]), 32'd1);

        $display("[TB] ch1 BLINK periods");
        apply_stimulus(1, 2, 2);
        wait_toggle(1, 40, n);
        wait_toggle(1, 40, n);
        check_output("blink_val2_a", 32'(n), 32'd12);
        wait_toggle(1, 40, n);
        check_output("blink_val2_b", 32'(n), 32'd12);
        apply_stimulus(1, 2, 0);
        wait_toggle(1, 40, n);
        wait_toggle(1, 40, n);
        wait_toggle(1, 40, n);
        check_output("blink_val0_a", 32'(n), 32'd4);
        wait_toggle(1, 40, n);
        check_output("blink_val0_b", 32'(n), 32'd4);

        $display("[TB] ch2 PWM duty");
        apply_stimulus(2, 3, 64);
        repeat (2) step();
        high = 0;
        for (int c = 0; c < PWM_LEN; c++) begin
            step();
            if (led_out[2]) high++;
        end
        check_output("pwm_64_high", 32'(high), 32'd64);
        apply_stimulus(2, 3, 0);
        repeat (2) step();
        high = 0;
        for (int c = 0; c < PWM_LEN; c++) begin
            step();
            if (led_out[2]) high++;
        end
        check_output("pwm_0_high", 32'(high), 32'd0);

        $display("[TB] out-of-range and back-to-back writes");
        apply_stimulus(3, 1, 5);
        check_output("bad_ch_err", 32'(cfg_bus.cfg_err), 32'd1);
        check_output("bad_ch_ack", 32'(cfg_bus.cfg_ack), 32'd0);
        step();
        check_output("bad_ch_err_end", 32'(cfg_bus.cfg_err), 32'd0);
        cfg_bus.cfg_we   = 1'b1;
        cfg_bus.cfg_ch   = 2'd3;
        step();
        check_output("b2b_err", 32'(cfg_bus.cfg_err), 32'd1);
        cfg_bus.cfg_ch   = 2'd0;
        cfg_bus.cfg_mode = 2'd0;
        step();
        cfg_bus.cfg_we   = 1'b0;
        check_output("b2b_ack", 32'(cfg_bus.cfg_ack), 32'd1);
        check_output("b2b_err_clear", 32'(cfg_bus.cfg_err), 32'd0);

        $display("[TB] write coinciding with tick");
        apply_stimulus(1, 0, 0);
        repeat (3) step();
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_out && n < 8);
        check_output("tick_sync", 32'(tick_out), 32'd1);
        repeat (3) step();
        apply_stimulus(1, 2, 1);
        check_output("tick_coincide", 32'(tick_out), 32'd1);
        wait_toggle(1, 30, n);
        check_output("first_toggle_edges", 32'(n), 32'd9);

        $display("[TB] reset mid-operation");
        apply_stimulus(0, 2, 0);
        apply_stimulus(2, 1, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (led_out == '0 && n < 10);
        check_output("pre_reset_active", 32'(led_out[2]), 32'd1);
        #2;
        fpga_rst = 1'b1;
        #1;
        check_output("async_reset_led", 32'(led_out), 32'd0);
        check_output("async_reset_tick", 32'(tick_out), 32'd0);
        step();
        fpga_rst = 1'b0;
        repeat (20) step();
        check_output("post_reset_led", 32'(led_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
